// File: rtl/clk_ratio_monitor.sv
// -----------------------------------------------------------------------------
// clk_ratio_monitor
//
// Recovers the period and high time (in clk cycles) of a clock produced by an
// integer divider running from clk. Each completed period, measured between two
// consecutive rising edges, is presented on a valid/ready handshake together
// with a comparison against the expected ratio N: period == N and
// high == floor(N/2). If no rising edge shows up for 2^WIDTH-1 cycles the
// partial measurement is dropped and stall_out is raised.
//
// Optional feature macro: CLK_MON_SYNC_EN
//   defined   : div_clk_in passes through a 2-flop synchronizer before the
//               sampling register (safe for an asynchronous source; +2 cycles
//               of latency).
//   undefined : div_clk_in is registered once (same-clock source).
//   The captured values are identical either way.
//
// Ports
//   clk            in   source clock
//   reset_n        in   synchronous active-low reset
//   en_in          in   monitor enable, low clears all measurement state
//   div_clk_in     in   divided clock under observation
//   exp_ratio_in   in   expected division ratio N          [WIDTH]
//   ratio_out      out  captured period in clk cycles      [WIDTH]
//   high_out       out  captured high time in clk cycles   [WIDTH]
//   meas_valid_out out  measurement available
//   meas_ready_in  in   consumer accepts the measurement
//   match_out      out  captured values match exp_ratio_in
//   overrun_out    out  sticky: unconsumed measurement was overwritten
//   stall_out      out  no rising edge for 2^WIDTH-1 cycles
// -----------------------------------------------------------------------------
module clk_ratio_monitor #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_in,
  input  logic             div_clk_in,
  input  logic [WIDTH-1:0] exp_ratio_in,
  output logic [WIDTH-1:0] ratio_out,
  output logic [WIDTH-1:0] high_out,
  output logic             meas_valid_out,
  input  logic             meas_ready_in,
  output logic             match_out,
  output logic             overrun_out,
  output logic             stall_out
);

  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEAS
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] period_reg, period_next;
  logic [WIDTH-1:0] high_cnt_reg, high_cnt_next;
  logic [WIDTH-1:0] ratio_reg, ratio_next;
  logic [WIDTH-1:0] high_reg, high_next;
  logic             valid_reg, valid_next;
  logic             match_reg, match_next;
  logic             overrun_reg, overrun_next;
  logic             stall_reg, stall_next;

  logic             s_cur_reg, s_prev_reg;
  logic             rise;
  logic             capture;
  logic             timeout;
  logic             cmp_match;

  // ---------------------------------------------------------------------------
  // Front end. These flops are deliberately left out of reset/enable: clearing
  // them would fabricate a rising edge when div_clk_in happens to be high as
  // the monitor comes out of reset, starting a measurement mid-period.
  // ---------------------------------------------------------------------------
`ifdef CLK_MON_SYNC_EN
  logic sync1_reg, sync2_reg;

  always_ff @(posedge clk) begin
    sync1_reg <= div_clk_in;
    sync2_reg <= sync1_reg;
    s_cur_reg <= sync2_reg;
  end
`else
  always_ff @(posedge clk) begin
    s_cur_reg <= div_clk_in;
  end
`endif

  always_ff @(posedge clk) begin
    s_prev_reg <= s_cur_reg;
  end

  assign rise = s_cur_reg & ~s_prev_reg;

  // Comparison is made against the counters as they stand at the capturing
  // edge, i.e. the values about to be loaded into ratio/high.
  assign cmp_match = (period_reg == exp_ratio_in) &&
                     (high_cnt_reg == (exp_ratio_in >> 1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      period_reg   <= CNT_ZERO;
      high_cnt_reg <= CNT_ZERO;
      ratio_reg    <= CNT_ZERO;
      high_reg     <= CNT_ZERO;
      valid_reg    <= 1'b0;
      match_reg    <= 1'b0;
      overrun_reg  <= 1'b0;
      stall_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      period_reg   <= period_next;
      high_cnt_reg <= high_cnt_next;
      ratio_reg    <= ratio_next;
      high_reg     <= high_next;
      valid_reg    <= valid_next;
      match_reg    <= match_next;
      overrun_reg  <= overrun_next;
      stall_reg    <= stall_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, counters and output registers
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    period_next   = period_reg;
    high_cnt_next = high_cnt_reg;
    ratio_next    = ratio_reg;
    high_next     = high_reg;
    valid_next    = valid_reg;
    match_next    = match_reg;
    overrun_next  = overrun_reg;
    stall_next    = stall_reg;
    capture       = 1'b0;
    timeout       = 1'b0;

    if (!en_in) begin
      // Disable wins over everything: drop any measurement and all status.
      state_next    = ST_IDLE;
      period_next   = CNT_ZERO;
      high_cnt_next = CNT_ZERO;
      ratio_next    = CNT_ZERO;
      high_next     = CNT_ZERO;
      valid_next    = 1'b0;
      match_next    = 1'b0;
      overrun_next  = 1'b0;
      stall_next    = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_ARM;
        end

        ST_ARM: begin
          // First rise only opens the measurement window.
          if (rise) begin
            state_next    = ST_MEAS;
            period_next   = CNT_ONE;
            high_cnt_next = CNT_ONE;
          end
        end

        ST_MEAS: begin
          if (rise) begin
            capture       = 1'b1;
            period_next   = CNT_ONE;
            high_cnt_next = CNT_ONE;
          end else if (period_reg == CNT_MAX) begin
            // Period counter cannot grow further: discard and re-arm.
            timeout       = 1'b1;
            state_next    = ST_ARM;
            period_next   = CNT_ZERO;
            high_cnt_next = CNT_ZERO;
          end else begin
            period_next = period_reg + 1'b1;
            if (s_cur_reg && (high_cnt_reg != CNT_MAX)) begin
              high_cnt_next = high_cnt_reg + 1'b1;
            end
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase

      // Handshake. A capture always wins; it only counts as an overrun when
      // the previous result is still pending and not being taken this cycle.
      if (capture) begin
        if (valid_reg && !meas_ready_in) begin
          overrun_next = 1'b1;
        end
        valid_next = 1'b1;
        ratio_next = period_reg;
        high_next  = high_cnt_reg;
        match_next = cmp_match;
        stall_next = 1'b0;
      end else if (valid_reg && meas_ready_in) begin
        valid_next = 1'b0;
      end

      if (timeout) begin
        stall_next = 1'b1;
      end
    end
  end

  assign ratio_out      = ratio_reg;
  assign high_out       = high_reg;
  assign meas_valid_out = valid_reg;
  assign match_out      = match_reg;
  assign overrun_out    = overrun_reg;
  assign stall_out      = stall_reg;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// -----------------------------------------------------------------------------
// Testbench for clk_ratio_monitor.
// A behavioural model works on the sampled waveform history: a period is the
// distance in clk edges between two observed rising edges, the high time is
// the number of high samples in that window, and the handshake is tracked as
// plain flags. Scenario tasks drive a software divider and compare the DUT
// against the model every cycle, plus fixed expectations for known ratios.
// -----------------------------------------------------------------------------
module tb_clk_ratio_monitor;

  localparam int WIDTH = 5;
  localparam int MAXC  = 31;
`ifdef CLK_MON_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             en_in;
  logic             div_clk_in;
  logic [WIDTH-1:0] exp_ratio_in;
  logic [WIDTH-1:0] ratio_out;
  logic [WIDTH-1:0] high_out;
  logic             meas_valid_out;
  logic             meas_ready_in;
  logic             match_out;
  logic             overrun_out;
  logic             stall_out;

  always #5 clk = ~clk;

  clk_ratio_monitor #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .en_in          (en_in),
    .div_clk_in     (div_clk_in),
    .exp_ratio_in   (exp_ratio_in),
    .ratio_out      (ratio_out),
    .high_out       (high_out),
    .meas_valid_out (meas_valid_out),
    .meas_ready_in  (meas_ready_in),
    .match_out      (match_out),
    .overrun_out    (overrun_out),
    .stall_out      (stall_out)
  );

  int checks = 0;
  int errors = 0;

  // Software divider
  bit   div_run;
  int   div_n;
  int   div_phase;
  logic div_level;

  // Reference model state
  logic [7:0] hist;
  int         m_j;
  bit         m_active;
  int         m_last;
  int         m_hi;
  int         m_rise_edge;
  bit         m_cap;
  bit         m_rise_armed;
  logic       m_valid, m_match, m_overrun, m_stall;
  logic [4:0] m_ratio, m_high;

  function automatic logic [13:0] dut_vec();
    return {meas_valid_out, ratio_out, high_out, match_out, overrun_out, stall_out};
  endfunction

  function automatic logic [13:0] mdl_vec();
    return {m_valid, m_ratio, m_high, m_match, m_overrun, m_stall};
  endfunction

  task automatic model_step();
    logic s, p, rise;
    int   per, cap_hi;
    bit   tout;
    per    = 0;
    cap_hi = 0;
    tout   = 0;
    m_j++;
    hist = {hist[6:0], div_clk_in};
    s    = hist[LAT];
    p    = hist[LAT+1];
    rise = s & ~p;
    m_cap        = 0;
    m_rise_armed = 0;
    if (!reset_n || !en_in) begin
      m_active = 0; m_last = -1; m_hi = 0;
      m_valid = 0; m_ratio = 0; m_high = 0; m_match = 0; m_overrun = 0; m_stall = 0;
    end else if (!m_active) begin
      m_active = 1;   // first enabled edge only arms the monitor
    end else begin
      if (rise) begin
        m_rise_armed = 1;
        if (m_last >= 0) begin
          per    = m_j - m_last;
          cap_hi = m_hi;
          m_cap  = 1;
        end
        m_last      = m_j;
        m_hi        = 1;
        m_rise_edge = m_j;
      end else if (m_last >= 0) begin
        if (m_j - m_last == MAXC) begin
          tout   = 1;
          m_last = -1;
        end else if (s && m_hi < MAXC) begin
          m_hi++;
        end
      end
      if (m_cap) begin
        if (m_valid && !meas_ready_in) m_overrun = 1;
        m_valid = 1;
        m_ratio = 5'(per);
        m_high  = 5'(cap_hi);
        m_match = (per == int'(exp_ratio_in)) && (cap_hi == int'(exp_ratio_in) / 2);
        m_stall = 0;
      end else if (m_valid && meas_ready_in) begin
        m_valid = 0;
      end
      if (tout) m_stall = 1;
    end
  endtask

  task automatic drive_div();
    if (div_run && div_n >= 2) begin
      div_clk_in = (div_phase < div_n / 2);
      div_phase  = (div_phase + 1) % div_n;
    end else begin
      div_clk_in = div_level;
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_step();
    #1;
    if (m_cap)
      $display("capture @%0t ratio=%0d high=%0d match=%0b overrun=%0b",
               $time, m_ratio, m_high, m_match, m_overrun);
  endtask

  task automatic tick();
    drive_div();
    edge_step();
  endtask

  task automatic restart_en(input int n, input int expv);
    en_in        = 1'b0;
    tick();
    div_run      = 1;
    div_n        = n;
    div_phase    = 0;
    exp_ratio_in = 5'(expv);
    en_in        = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b0; en_in = 1'b1; meas_ready_in = 1'b1;
    div_run = 1; div_n = 6; div_phase = 0; exp_ratio_in = 5'd6;
    repeat (4) tick();
    checks++; if (ratio_out !== 5'd0)    begin errors++; $display("FAIL reset_ratio got %0d exp 0", ratio_out); end
    checks++; if (high_out !== 5'd0)     begin errors++; $display("FAIL reset_high got %0d exp 0", high_out); end
    checks++; if (meas_valid_out !== 0)  begin errors++; $display("FAIL reset_valid got %b exp 0", meas_valid_out); end
    checks++; if (match_out !== 0)       begin errors++; $display("FAIL reset_match got %b exp 0", match_out); end
    checks++; if (overrun_out !== 0)     begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun_out); end
    checks++; if (stall_out !== 0)       begin errors++; $display("FAIL reset_stall got %b exp 0", stall_out); end
    reset_n = 1'b1;
  endtask

  task automatic test_ratio6();
    int n_valid, rises;
    bit first;
    n_valid = 0; rises = 0; first = 0;
    meas_ready_in = 1'b1;
    restart_en(6, 6);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (m_rise_armed) rises++;
      checks++; if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL ratio6_model t=%0t got %h exp %h", $time, dut_vec(), mdl_vec()); end
      if (meas_valid_out === 1'b1) begin
        n_valid++;
        if (!first) begin
          first = 1;
          checks++; if (rises !== 2) begin errors++; $display("FAIL ratio6_first_rise got %0d exp 2", rises); end
        end
        checks++; if ({ratio_out, high_out, match_out} !== {5'd6, 5'd3, 1'b1})
          begin errors++; $display("FAIL ratio6_capture got r=%0d h=%0d m=%b exp r=6 h=3 m=1", ratio_out, high_out, match_out); end
      end
    end
    checks++; if (n_valid < 8) begin errors++; $display("FAIL ratio6_count got %0d exp >=8", n_valid); end
  endtask

  task automatic test_mismatch();
    int n_valid;
    n_valid = 0;
    meas_ready_in = 1'b1;
    restart_en(5, 6);
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++; if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL mismatch_model t=%0t got %h exp %h", $time, dut_vec(), mdl_vec()); end
      if (meas_valid_out === 1'b1) begin
        n_valid++;
        checks++; if ({ratio_out, high_out, match_out} !== {5'd5, 5'd2, 1'b0})
          begin errors++; $display("FAIL mismatch_capture got r=%0d h=%0d m=%b exp r=5 h=2 m=0", ratio_out, high_out, match_out); end
      end
    end
    checks++; if (n_valid < 4) begin errors++; $display("FAIL mismatch_count got %0d exp >=4", n_valid); end
  endtask

  task automatic test_overrun();
    bit got;
    got = 0;
    meas_ready_in = 1'b0;
    restart_en(4, 4);
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      if (meas_valid_out === 1'b1) got = 1;
    end
    checks++; if (!got) begin errors++; $display("FAIL overrun_first_valid got none exp capture"); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (meas_valid_out !== 1'b1) begin errors++; $display("FAIL overrun_hold got %b exp 1", meas_valid_out); end
      checks++; if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL overrun_model t=%0t got %h exp %h", $time, dut_vec(), mdl_vec()); end
    end
    checks++; if ({overrun_out, ratio_out, high_out} !== {1'b1, 5'd4, 5'd2})
      begin errors++; $display("FAIL overrun_set got o=%b r=%0d h=%0d exp o=1 r=4 h=2", overrun_out, ratio_out, high_out); end
    meas_ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (overrun_out !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b exp 1", overrun_out); end
    end
    en_in = 1'b0;
    tick();
    checks++; if (dut_vec() !== 14'h0) begin errors++; $display("FAIL overrun_clear got %h exp 0", dut_vec()); end
  endtask

  task automatic test_stall();
    bit found, cleared;
    int rises;
    found = 0; cleared = 0; rises = 0;
    meas_ready_in = 1'b1;
    restart_en(8, 8);
    repeat (40) tick();
    div_run = 0; div_level = 1'b0;
    for (int i = 0; i < 70; i++) begin
      tick();
      checks++; if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL stall_model t=%0t got %h exp %h", $time, dut_vec(), mdl_vec()); end
      if (!found && stall_out === 1'b1) begin
        found = 1;
        checks++; if (m_j - m_rise_edge !== MAXC) begin errors++; $display("FAIL stall_timing got %0d exp %0d", m_j - m_rise_edge, MAXC); end
        checks++; if (meas_valid_out !== 1'b0) begin errors++; $display("FAIL stall_no_capture got %b exp 0", meas_valid_out); end
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL stall_seen got 0 exp 1"); end
    div_run = 1; div_phase = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m_rise_armed) rises++;
      if (!cleared && stall_out === 1'b0) begin
        cleared = 1;
        checks++; if (rises !== 2) begin errors++; $display("FAIL stall_clear_rise got %0d exp 2", rises); end
        checks++; if (meas_valid_out !== 1'b1) begin errors++; $display("FAIL stall_clear_valid got %b exp 1", meas_valid_out); end
      end
    end
    checks++; if (!cleared) begin errors++; $display("FAIL stall_cleared got 0 exp 1"); end
  endtask

  task automatic test_reset_mid();
    bit got;
    int rises;
    got = 0; rises = 0;
    meas_ready_in = 1'b1;
    restart_en(6, 6);
    repeat (17) tick();
    reset_n = 1'b0;
    tick();
    checks++; if (dut_vec() !== 14'h0) begin errors++; $display("FAIL reset_mid_zero got %h exp 0", dut_vec()); end
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m_rise_armed) rises++;
      checks++; if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL reset_mid_model t=%0t got %h exp %h", $time, dut_vec(), mdl_vec()); end
      if (!got && meas_valid_out === 1'b1) begin
        got = 1;
        checks++; if (rises !== 2) begin errors++; $display("FAIL reset_mid_rearm got %0d exp 2", rises); end
      end
    end
    checks++; if (!got) begin errors++; $display("FAIL reset_mid_capture got none exp capture"); end
  endtask

  task automatic test_back_to_back();
    int caps;
    caps = 0;
    meas_ready_in = 1'b0;
    restart_en(6, 6);
    for (int i = 0; i < 50; i++) begin
      drive_div();
      // Accept only on the cycle in which the next capture lands.
      meas_ready_in = hist[LAT-1] & ~hist[LAT];
      edge_step();
      checks++; if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL b2b_model t=%0t got %h exp %h", $time, dut_vec(), mdl_vec()); end
      if (m_cap) begin
        if (caps > 0) begin
          checks++; if ({meas_valid_out, overrun_out, ratio_out} !== {1'b1, 1'b0, 5'd6})
            begin errors++; $display("FAIL b2b_capture got v=%b o=%b r=%0d exp v=1 o=0 r=6", meas_valid_out, overrun_out, ratio_out); end
        end
        caps++;
      end
    end
    checks++; if (caps < 6) begin errors++; $display("FAIL b2b_count got %0d exp >=6", caps); end
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 8; seg++) begin
      div_n        = $urandom_range(0, 40);
      div_level    = 1'($urandom_range(0, 1));
      div_phase    = (div_n > 1) ? $urandom_range(0, div_n - 1) : 0;
      div_run      = 1;
      exp_ratio_in = ($urandom_range(0, 1) == 1) ? ((div_n > MAXC) ? 5'd31 : 5'(div_n))
                                                 : 5'($urandom_range(0, MAXC));
      for (int i = 0; i < 90; i++) begin
        meas_ready_in = ($urandom_range(0, 3) != 0);
        en_in         = ($urandom_range(0, 199) != 0);
        reset_n       = ($urandom_range(0, 299) != 0);
        tick();
        checks++; if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL random_model seg=%0d n=%0d t=%0t got %h exp %h", seg, div_n, $time, dut_vec(), mdl_vec()); end
      end
    end
    reset_n = 1'b1;
    en_in   = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; en_in = 1'b0; div_clk_in = 1'b0; exp_ratio_in = '0; meas_ready_in = 1'b0;
    div_run = 0; div_n = 0; div_phase = 0; div_level = 1'b0;
    hist = '0; m_j = 0; m_active = 0; m_last = -1; m_hi = 0; m_rise_edge = 0;
    m_cap = 0; m_rise_armed = 0;
    m_valid = 0; m_match = 0; m_overrun = 0; m_stall = 0; m_ratio = '0; m_high = '0;

    test_reset();
    test_ratio6();
    test_mismatch();
    test_overrun();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
